// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to unsigned binary converter, one digit per clock, MSD first.
// Saturates to all ones with ovf above 2**BIN_W-1; any digit above 9 forces zero with err.
module bcd2bin_seq #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                ovf,
  output logic                err
);

  localparam int unsigned AW    = 4 * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW    = ((AW > BIN_W) ? AW : BIN_W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [AW-1:0]    acc, acc_nxt;
  logic [AW-1:0]    shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             bad, bad_nxt;
  logic             busy_nxt, done_nxt;
  logic [BIN_W-1:0] bin_nxt;
  logic             ovf_nxt, err_nxt;

  logic [3:0]       digit_c;
  logic [AW-1:0]    acc_step_c;
  logic             bad_step_c;
  logic             sat_c;

  // Multiply-by-10 accumulate on the current MSD; accumulator width never wraps.
  always_comb begin
    digit_c    = shreg[AW-1 -: 4];
    acc_step_c = (acc << 3) + (acc << 1) + AW'(digit_c);
    bad_step_c = bad | (digit_c > 4'd9);
    sat_c      = CW'(acc_step_c) > CW'({BIN_W{1'b1}});
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    bad_nxt   = bad;
    bin_nxt   = bin_out;
    ovf_nxt   = ovf;
    err_nxt   = err;

    case (state)
      S_IDLE, S_DONE: begin
        // DONE also accepts start so conversions can run back-to-back.
        if (start) begin
          shreg_nxt = bcd_in;
          acc_nxt   = '0;
          cnt_nxt   = CNT_W'(DIGITS - 1);
          bad_nxt   = 1'b0;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        acc_nxt   = acc_step_c;
        shreg_nxt = shreg << 4;
        bad_nxt   = bad_step_c;
        cnt_nxt   = cnt - CNT_W'(1);
        if (cnt == '0) begin
          state_nxt = S_DONE;
          err_nxt   = bad_step_c;
          if (bad_step_c) begin
            bin_nxt = '0;
            ovf_nxt = 1'b0;
          end else if (sat_c) begin
            bin_nxt = '1;
            ovf_nxt = 1'b1;
          end else begin
            bin_nxt = BIN_W'(acc_step_c);
            ovf_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt == S_RUN);
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      shreg   <= '0;
      cnt     <= '0;
      bad     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      bad     <= bad_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      bin_out <= bin_nxt;
      ovf     <= ovf_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq (DIGITS=3, BIN_W=8): directed cases plus
// randomized conversions compared against a decimal-arithmetic reference model.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [7:0]  bin_out;
  logic        ovf;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [9:0] held;  // {err, ovf, bin_out} last produced result

  always #5 clk = ~clk;

  bcd2bin_seq #(.DIGITS(3), .BIN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .ovf(ovf), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal value of the BCD word, then error / saturation rules.
  function automatic logic [9:0] model(input logic [11:0] bcd);
    int v;
    bit e;
    logic [11:0] w;
    v = 0;
    e = 1'b0;
    w = bcd;
    for (int k = 2; k >= 0; k--) begin
      int d;
      d = int'(w[4*k +: 4]);
      if (d > 9) e = 1'b1;
      v = v * 10 + d;
    end
    if (e) return {1'b1, 1'b0, 8'h00};
    if (v > 255) return {1'b0, 1'b1, 8'hFF};
    return {1'b0, 1'b0, 8'(v)};
  endfunction

  // Called at the negedge following cycle lat0 after the accepting edge.
  task automatic wait_done(input string tag, input int lat0, input int exp_busy);
    int lat;
    int bc;
    lat = lat0;
    bc  = 0;
    while (!done && lat < 12) begin
      if (busy) bc++;
      check({tag, ":hold"}, 32'({err, ovf, bin_out}), 32'(held));
      @(negedge clk);
      lat++;
    end
    check({tag, ":lat"}, 32'(lat), 32'd4);
    check({tag, ":busycnt"}, 32'(bc), 32'(exp_busy));
    check({tag, ":overlap"}, 32'(busy & done), 32'd0);
  endtask

  task automatic run_conv(input logic [11:0] bcd, input string tag);
    logic [9:0] exp;
    exp = model(bcd);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = bcd;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 12'($urandom);
    wait_done(tag, 1, 3);
    check({tag, ":res"}, 32'({err, ovf, bin_out}), 32'(exp));
    held = exp;
    @(negedge clk);
    check({tag, ":pulse"}, 32'(done), 32'd0);
    check({tag, ":held"}, 32'({err, ovf, bin_out}), 32'(held));
  endtask

  initial begin
    logic [9:0]  exp;
    logic [11:0] b;

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    held   = '0;
    #12;
    check("rst:outs", 32'({busy, done, err, ovf, bin_out}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle clears held outputs at once
    run_conv(12'h200, "pre");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("arst:outs", 32'({busy, done, err, ovf, bin_out}), 32'd0);
    held = '0;
    @(negedge clk);
    rst_n = 1'b1;

    run_conv(12'h255, "t255");
    run_conv(12'h256, "t256");
    run_conv(12'h000, "t000");
    run_conv(12'h1A3, "t1a3");
    run_conv(12'h042, "t042");
    run_conv(12'h999, "t999");
    run_conv(12'hF00, "tf00");

    // start during busy ignored, then start held through the done cycle
    exp = model(12'h042);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h042;
    @(negedge clk);
    check("t5:busy", 32'(busy), 32'd1);
    bcd_in = 12'h999;
    @(negedge clk);
    start  = 1'b0;
    wait_done("t5a", 2, 2);
    check("t5a:res", 32'({err, ovf, bin_out}), 32'(exp));
    held   = exp;
    start  = 1'b1;
    bcd_in = 12'h123;
    exp    = model(12'h123);
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 12'h888;
    wait_done("t5b", 1, 3);
    check("t5b:res", 32'({err, ovf, bin_out}), 32'(exp));
    held = exp;
    @(negedge clk);

    // Reset after two RUN cycles discards the conversion
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h123;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t6:outs", 32'({busy, done, err, ovf, bin_out}), 32'd0);
    held = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6:nodone", 32'({busy, done}), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6:idle", 32'({busy, done, err, ovf, bin_out}), 32'd0);
    end
    run_conv(12'h123, "t6r");

    // Randomized: mostly valid digits, sometimes arbitrary nibbles
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 12'($urandom);
      end else begin
        b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      run_conv(b, "rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
